// File: rtl/exe_stage.sv
// exe_stage: execute pipeline stage between decode and memory access.
// Two-entry elastic buffer: S holds latched operands and feeds the ALU,
// O holds the captured result for the memory stage. Supports backpressure,
// flush and full throughput.
// Optional forwarding to decode is enabled by defining EXE_BYPASS_EN;
// without it the es_fwd_* ports are tied to zero.

// One-hot ALU. Bit map: 0 add, 1 sub, 2 slt, 3 sltu, 4 and, 5 nor, 6 or,
// 7 xor, 8 sll, 9 srl, 10 sra, 11 lui (pass src2), 12 andn, 13 orn.
module alu (
  input  logic [13:0] alu_op,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  output logic [31:0] alu_result
);
  logic [4:0]  sh_s;
  logic [31:0] add_s;
  logic [31:0] sub_s;

  assign sh_s  = alu_src2[4:0];
  assign add_s = alu_src1 + alu_src2;
  assign sub_s = alu_src1 - alu_src2;

  // OR together the masked per-op results; one-hot select keeps at most one active
  always_comb begin
    alu_result = 32'd0;
    alu_result = alu_result | ({32{alu_op[0]}}  & add_s);
    alu_result = alu_result | ({32{alu_op[1]}}  & sub_s);
    alu_result = alu_result | ({32{alu_op[2]}}  & {31'd0, ($signed(alu_src1) < $signed(alu_src2))});
    alu_result = alu_result | ({32{alu_op[3]}}  & {31'd0, (alu_src1 < alu_src2)});
    alu_result = alu_result | ({32{alu_op[4]}}  & (alu_src1 & alu_src2));
    alu_result = alu_result | ({32{alu_op[5]}}  & ~(alu_src1 | alu_src2));
    alu_result = alu_result | ({32{alu_op[6]}}  & (alu_src1 | alu_src2));
    alu_result = alu_result | ({32{alu_op[7]}}  & (alu_src1 ^ alu_src2));
    alu_result = alu_result | ({32{alu_op[8]}}  & (alu_src1 << sh_s));
    alu_result = alu_result | ({32{alu_op[9]}}  & (alu_src1 >> sh_s));
    alu_result = alu_result | ({32{alu_op[10]}} & 32'($signed(alu_src1) >>> sh_s));
    alu_result = alu_result | ({32{alu_op[11]}} & alu_src2);
    alu_result = alu_result | ({32{alu_op[12]}} & (alu_src1 & ~alu_src2));
    alu_result = alu_result | ({32{alu_op[13]}} & (alu_src1 | ~alu_src2));
  end
endmodule

module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ds_to_es_valid,
  output logic        es_allowin,
  input  logic [13:0] id_alu_op,
  input  logic [31:0] id_src1,
  input  logic [31:0] id_src2,
  input  logic [4:0]  id_dest,
  input  logic        id_gr_we,
  input  logic [31:0] id_pc,
  input  logic        flush,
  input  logic        ms_allowin,
  output logic        es_to_ms_valid,
  output logic [31:0] es_pc,
  output logic [31:0] es_result,
  output logic [4:0]  es_dest,
  output logic        es_gr_we,
  output logic        es_fwd_s_valid,
  output logic        es_fwd_o_valid,
  output logic [4:0]  es_fwd_s_dest,
  output logic [4:0]  es_fwd_o_dest,
  output logic [31:0] es_fwd_s_data,
  output logic [31:0] es_fwd_o_data
);
  logic        s_valid_q, s_valid_d;
  logic [13:0] s_op_q, s_op_d;
  logic [31:0] s_src1_q, s_src1_d;
  logic [31:0] s_src2_q, s_src2_d;
  logic [4:0]  s_dest_q, s_dest_d;
  logic        s_we_q, s_we_d;
  logic [31:0] s_pc_q, s_pc_d;
  logic        o_valid_q, o_valid_d;
  logic [31:0] o_result_q, o_result_d;
  logic [4:0]  o_dest_q, o_dest_d;
  logic        o_we_q, o_we_d;
  logic [31:0] o_pc_q, o_pc_d;

  logic        o_allowin_s;
  logic        s_allowin_s;
  logic        accept_s;
  logic        s_to_o_s;
  logic        o_hs_s;
  logic [31:0] alu_result_s;

  alu u_alu (
    .alu_op     (s_op_q),
    .alu_src1   (s_src1_q),
    .alu_src2   (s_src2_q),
    .alu_result (alu_result_s)
  );

  // Ready chain and transfer conditions; flush blocks every transfer
  always_comb begin
    o_allowin_s    = !o_valid_q | ms_allowin;
    s_allowin_s    = !s_valid_q | o_allowin_s;
    es_allowin     = s_allowin_s & !rst;
    accept_s       = ds_to_es_valid & es_allowin & !flush;
    s_to_o_s       = s_valid_q & o_allowin_s & !flush;
    es_to_ms_valid = o_valid_q & !flush;
    o_hs_s         = es_to_ms_valid & ms_allowin;
  end

  // Next-state for valid bits and payloads; payloads load only on their transfer
  always_comb begin
    s_op_d     = s_op_q;
    s_src1_d   = s_src1_q;
    s_src2_d   = s_src2_q;
    s_dest_d   = s_dest_q;
    s_we_d     = s_we_q;
    s_pc_d     = s_pc_q;
    o_result_d = o_result_q;
    o_dest_d   = o_dest_q;
    o_we_d     = o_we_q;
    o_pc_d     = o_pc_q;

    if (flush) begin
      s_valid_d = 1'b0;
    end else if (accept_s) begin
      s_valid_d = 1'b1;
    end else if (s_to_o_s) begin
      s_valid_d = 1'b0;
    end else begin
      s_valid_d = s_valid_q;
    end

    if (flush) begin
      o_valid_d = 1'b0;
    end else if (s_to_o_s) begin
      o_valid_d = 1'b1;
    end else if (o_hs_s) begin
      o_valid_d = 1'b0;
    end else begin
      o_valid_d = o_valid_q;
    end

    if (accept_s) begin
      s_op_d   = id_alu_op;
      s_src1_d = id_src1;
      s_src2_d = id_src2;
      s_dest_d = id_dest;
      s_we_d   = id_gr_we;
      s_pc_d   = id_pc;
    end else begin
      s_op_d   = s_op_q;
    end

    if (s_to_o_s) begin
      o_result_d = alu_result_s;
      o_dest_d   = s_dest_q;
      o_we_d     = s_we_q;
      o_pc_d     = s_pc_q;
    end else begin
      o_result_d = o_result_q;
    end
  end

  // State registers; asynchronous reset clears both entries and all payloads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_valid_q  <= 1'b0;
      s_op_q     <= 14'd0;
      s_src1_q   <= 32'd0;
      s_src2_q   <= 32'd0;
      s_dest_q   <= 5'd0;
      s_we_q     <= 1'b0;
      s_pc_q     <= 32'd0;
      o_valid_q  <= 1'b0;
      o_result_q <= 32'd0;
      o_dest_q   <= 5'd0;
      o_we_q     <= 1'b0;
      o_pc_q     <= 32'd0;
    end else begin
      s_valid_q  <= s_valid_d;
      s_op_q     <= s_op_d;
      s_src1_q   <= s_src1_d;
      s_src2_q   <= s_src2_d;
      s_dest_q   <= s_dest_d;
      s_we_q     <= s_we_d;
      s_pc_q     <= s_pc_d;
      o_valid_q  <= o_valid_d;
      o_result_q <= o_result_d;
      o_dest_q   <= o_dest_d;
      o_we_q     <= o_we_d;
      o_pc_q     <= o_pc_d;
    end
  end

  assign es_pc     = o_pc_q;
  assign es_result = o_result_q;
  assign es_dest   = o_dest_q;
  assign es_gr_we  = o_we_q;

`ifdef EXE_BYPASS_EN
  // S channel forwards the live ALU result; O channel forwards the captured one
  assign es_fwd_s_valid = s_valid_q & s_we_q & !flush;
  assign es_fwd_s_dest  = s_dest_q;
  assign es_fwd_s_data  = alu_result_s;
  assign es_fwd_o_valid = o_valid_q & o_we_q & !flush;
  assign es_fwd_o_dest  = o_dest_q;
  assign es_fwd_o_data  = o_result_q;
`else
  assign es_fwd_s_valid = 1'b0;
  assign es_fwd_s_dest  = 5'd0;
  assign es_fwd_s_data  = 32'd0;
  assign es_fwd_o_valid = 1'b0;
  assign es_fwd_o_dest  = 5'd0;
  assign es_fwd_o_data  = 32'd0;
`endif
endmodule

// File: tb/tb_exe_stage.sv
// Directed testbench for exe_stage: latency, wrap, streaming, backpressure,
// flush, asynchronous reset and forwarding (EXE_BYPASS_EN selects checks).
module tb_exe_stage;
  logic        clk;
  logic        rst;
  logic        ds_to_es_valid;
  logic        es_allowin;
  logic [13:0] id_alu_op;
  logic [31:0] id_src1;
  logic [31:0] id_src2;
  logic [4:0]  id_dest;
  logic        id_gr_we;
  logic [31:0] id_pc;
  logic        flush;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [31:0] es_pc;
  logic [31:0] es_result;
  logic [4:0]  es_dest;
  logic        es_gr_we;
  logic        es_fwd_s_valid;
  logic        es_fwd_o_valid;
  logic [4:0]  es_fwd_s_dest;
  logic [4:0]  es_fwd_o_dest;
  logic [31:0] es_fwd_s_data;
  logic [31:0] es_fwd_o_data;

  int n_cmp;
  int n_err;

  exe_stage dut (
    .clk            (clk),
    .rst            (rst),
    .ds_to_es_valid (ds_to_es_valid),
    .es_allowin     (es_allowin),
    .id_alu_op      (id_alu_op),
    .id_src1        (id_src1),
    .id_src2        (id_src2),
    .id_dest        (id_dest),
    .id_gr_we       (id_gr_we),
    .id_pc          (id_pc),
    .flush          (flush),
    .ms_allowin     (ms_allowin),
    .es_to_ms_valid (es_to_ms_valid),
    .es_pc          (es_pc),
    .es_result      (es_result),
    .es_dest        (es_dest),
    .es_gr_we       (es_gr_we),
    .es_fwd_s_valid (es_fwd_s_valid),
    .es_fwd_o_valid (es_fwd_o_valid),
    .es_fwd_s_dest  (es_fwd_s_dest),
    .es_fwd_o_dest  (es_fwd_o_dest),
    .es_fwd_s_data  (es_fwd_s_data),
    .es_fwd_o_data  (es_fwd_o_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d, input logic we, input logic [31:0] pc);
    ds_to_es_valid = v;
    id_alu_op      = 14'd1;
    id_src1        = a;
    id_src2        = b;
    id_dest        = d;
    id_gr_we       = we;
    id_pc          = pc;
  endtask

  // Single op through an empty stage with ms_allowin=1; call just after an edge
  task automatic send_one(input logic [31:0] a, input logic [31:0] b, input logic [4:0] d,
                          input logic we, input logic [31:0] pc, input logic [31:0] exp);
    ms_allowin = 1'b1;
    drive(1'b1, a, b, d, we, pc);
    #1;
    check("one_allowin_empty", {31'd0, es_allowin}, 32'd1);
    check("one_valid_pre", {31'd0, es_to_ms_valid}, 32'd0);
    tick();
    ds_to_es_valid = 1'b0;
    #1;
    check("one_valid_s_cycle", {31'd0, es_to_ms_valid}, 32'd0);
`ifdef EXE_BYPASS_EN
    check("fwd_s_valid", {31'd0, es_fwd_s_valid}, {31'd0, we});
    check("fwd_o_valid_in_s", {31'd0, es_fwd_o_valid}, 32'd0);
    if (we) begin
      check("fwd_s_dest", {27'd0, es_fwd_s_dest}, {27'd0, d});
      check("fwd_s_data", es_fwd_s_data, exp);
    end
`else
    check("fwd_s_zero", {31'd0, es_fwd_s_valid} | {27'd0, es_fwd_s_dest} | es_fwd_s_data, 32'd0);
`endif
    tick();
    #1;
    check("one_valid_o_cycle", {31'd0, es_to_ms_valid}, 32'd1);
    check("one_result", es_result, exp);
    check("one_dest", {27'd0, es_dest}, {27'd0, d});
    check("one_gr_we", {31'd0, es_gr_we}, {31'd0, we});
    check("one_pc", es_pc, pc);
`ifdef EXE_BYPASS_EN
    check("fwd_o_valid", {31'd0, es_fwd_o_valid}, {31'd0, we});
    check("fwd_s_valid_in_o", {31'd0, es_fwd_s_valid}, 32'd0);
    if (we) begin
      check("fwd_o_dest", {27'd0, es_fwd_o_dest}, {27'd0, d});
      check("fwd_o_data", es_fwd_o_data, exp);
    end
`else
    check("fwd_o_zero", {31'd0, es_fwd_o_valid} | {27'd0, es_fwd_o_dest} | es_fwd_o_data, 32'd0);
`endif
    tick();
    #1;
    check("one_valid_after", {31'd0, es_to_ms_valid}, 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    flush = 1'b0;
    ms_allowin = 1'b1;
    drive(1'b1, 32'd9, 32'd9, 5'd1, 1'b1, 32'h10);

    // Reset values while rst is high, even with an op offered
    #2;
    check("rst_allowin", {31'd0, es_allowin}, 32'd0);
    check("rst_valid", {31'd0, es_to_ms_valid}, 32'd0);
    check("rst_result", es_result, 32'd0);
    check("rst_pc", es_pc, 32'd0);
    check("rst_dest_we", {26'd0, es_dest, es_gr_we}, 32'd0);
    check("rst_fwd", {30'd0, es_fwd_s_valid, es_fwd_o_valid} | es_fwd_s_data | es_fwd_o_data, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    ds_to_es_valid = 1'b0;
    tick();

    // Single op and wrap-around add
    send_one(32'd5, 32'd7, 5'd3, 1'b1, 32'h1c000000, 32'd12);
    send_one(32'hFFFFFFFF, 32'd1, 5'd4, 1'b1, 32'h1c000004, 32'd0);
    // Forwarding op, then the same with gr_we=0
    send_one(32'd3, 32'd4, 5'd5, 1'b1, 32'h1c000008, 32'd7);
    send_one(32'd3, 32'd4, 5'd5, 1'b0, 32'h1c00000c, 32'd7);

    // Back-to-back stream of 8 adds (i + 100); op offered in cycle c shows in cycle c+2
    ms_allowin = 1'b1;
    for (int c = 0; c < 11; c++) begin
      if (c < 8) drive(1'b1, c, 32'd100, 5'(c + 1), 1'b1, 32'h2000 + 32'(c * 4));
      else ds_to_es_valid = 1'b0;
      #1;
      check("stream_allowin", {31'd0, es_allowin}, 32'd1);
      if (c >= 2 && c < 10) begin
        check("stream_valid", {31'd0, es_to_ms_valid}, 32'd1);
        check("stream_result", es_result, 32'(c - 2) + 32'd100);
        check("stream_pc", es_pc, 32'h2000 + 32'((c - 2) * 4));
      end else begin
        check("stream_idle", {31'd0, es_to_ms_valid}, 32'd0);
      end
      tick();
    end

    // Backpressure: three ops offered with ms_allowin=0, only two fit
    ms_allowin = 1'b0;
    drive(1'b1, 32'd1, 32'd10, 5'd7, 1'b1, 32'h3000);
    #1;
    check("bp_allowin_c0", {31'd0, es_allowin}, 32'd1);
    tick();
    drive(1'b1, 32'd2, 32'd20, 5'd8, 1'b1, 32'h3004);
    #1;
    check("bp_allowin_c1", {31'd0, es_allowin}, 32'd1);
    tick();
    drive(1'b1, 32'd3, 32'd30, 5'd9, 1'b1, 32'h3008);
    #1;
    check("bp_allowin_c2", {31'd0, es_allowin}, 32'd0);
    check("bp_valid_c2", {31'd0, es_to_ms_valid}, 32'd1);
    check("bp_result_c2", es_result, 32'd11);
    tick();
    #1;
    check("bp_allowin_c3", {31'd0, es_allowin}, 32'd0);
    check("bp_result_hold", es_result, 32'd11);
    ds_to_es_valid = 1'b0;
    ms_allowin = 1'b1;
    #1;
    check("bp_allowin_release", {31'd0, es_allowin}, 32'd1);
    tick();
    #1;
    check("bp_valid_b", {31'd0, es_to_ms_valid}, 32'd1);
    check("bp_result_b", es_result, 32'd22);
    check("bp_dest_b", {27'd0, es_dest}, 32'd8);
    tick();
    #1;
    check("bp_drained", {31'd0, es_to_ms_valid}, 32'd0);

    // Flush with S and O full; a concurrent offer with es_allowin=1 is dropped
    ms_allowin = 1'b0;
    drive(1'b1, 32'd40, 32'd1, 5'd10, 1'b1, 32'h4000);
    tick();
    drive(1'b1, 32'd50, 32'd1, 5'd11, 1'b1, 32'h4004);
    tick();
    drive(1'b1, 32'd60, 32'd1, 5'd12, 1'b1, 32'h4008);
    ms_allowin = 1'b1;
    flush = 1'b1;
    #1;
    check("fl_valid_flush_cycle", {31'd0, es_to_ms_valid}, 32'd0);
    check("fl_fwd_flush_cycle", {30'd0, es_fwd_s_valid, es_fwd_o_valid}, 32'd0);
    tick();
    flush = 1'b0;
    ds_to_es_valid = 1'b0;
    #1;
    check("fl_valid_after1", {31'd0, es_to_ms_valid}, 32'd0);
    tick();
    #1;
    check("fl_valid_after2", {31'd0, es_to_ms_valid}, 32'd0);
    check("fl_allowin_after", {31'd0, es_allowin}, 32'd1);
    send_one(32'd20, 32'd22, 5'd13, 1'b1, 32'h5000, 32'd42);

    // Asynchronous reset mid-operation discards the op in O immediately
    drive(1'b1, 32'd8, 32'd8, 5'd14, 1'b1, 32'h6000);
    tick();
    ds_to_es_valid = 1'b0;
    tick();
    #1;
    check("mr_valid_before", {31'd0, es_to_ms_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("mr_valid", {31'd0, es_to_ms_valid}, 32'd0);
    check("mr_result", es_result, 32'd0);
    check("mr_allowin", {31'd0, es_allowin}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    #1;
    check("mr_valid_post", {31'd0, es_to_ms_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
